// File: rtl/ram_arbiter_2p.sv
// Two-requester round-robin front end for a single-port RAM with registered read.
// Commands are granted combinationally, launched to the RAM one cycle later, read data routed back after two.
module ram_arbiter_2p #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,

  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,

  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  // ptr names the requester that wins when both are valid
  logic ptr;
  logic acc0, acc1, acc, sel;
  logic win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  logic rd_v1, rd_id1;
  logic rd_v2, rd_id2;

  assign req0_ready = req0_valid & (~req1_valid | ~ptr);
  assign req1_ready = req1_valid & (~req0_valid |  ptr);

  assign acc0 = req0_valid & req0_ready;
  assign acc1 = req1_valid & req1_ready;
  assign acc  = acc0 | acc1;
  assign sel  = acc1;

  assign win_we    = sel ? req1_we    : req0_we;
  assign win_addr  = sel ? req1_addr  : req0_addr;
  assign win_wdata = sel ? req1_wdata : req0_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      ptr      <= 1'b0;
      rd_v1    <= 1'b0;
      rd_id1   <= 1'b0;
      rd_v2    <= 1'b0;
      rd_id2   <= 1'b0;
    end else begin
      ram_we <= acc & win_we;
      if (acc) begin
        ram_addr <= win_addr;
        ram_data <= win_wdata;
        ptr      <= ~sel;
      end
      // stage 1 lines up with the address on the RAM pins, stage 2 with ram_q
      rd_v1  <= acc & ~win_we;
      rd_id1 <= sel;
      rd_v2  <= rd_v1;
      rd_id2 <= rd_id1;
    end
  end

  assign req0_rvalid = rd_v2 & ~rd_id2;
  assign req1_rvalid = rd_v2 &  rd_id2;
  assign req0_rdata  = req0_rvalid ? ram_q : '0;
  assign req1_rdata  = req1_rvalid ? ram_q : '0;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Bench for ram_arbiter_2p: behavioural RAM, acceptance-order reference model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_ram_arbiter_2p;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req0_we = 1'b0;
  logic [5:0] req0_addr = '0;
  logic [7:0] req0_wdata = '0;
  logic       req0_ready, req0_rvalid;
  logic [7:0] req0_rdata;
  logic       req1_valid = 1'b0, req1_we = 1'b0;
  logic [5:0] req1_addr = '0;
  logic [7:0] req1_wdata = '0;
  logic       req1_ready, req1_rvalid;
  logic [7:0] req1_rdata;
  logic [7:0] ram_data;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_q = '0;

  int n_pass = 0;
  int n_total = 0;

  ram_arbiter_2p #(.DATA_W(8), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // single-port RAM with registered read
  logic [7:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // reference model: commands take effect in acceptance order; a read returns
  // the contents as of its acceptance, two cycles later
  typedef struct { int due; bit id; logic [7:0] data; } ret_t;
  ret_t       m_q[$];
  bit         m_ptr = 1'b0;
  bit         m_we = 1'b0;
  logic [5:0] m_addr = '0;
  logic [7:0] m_data = '0;
  logic [7:0] shadow [64];
  int         cyc = 0;
  initial for (int i = 0; i < 64; i++) shadow[i] = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_ptr = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      bit g0, g1, id, we;
      logic [5:0] a;
      logic [7:0] d;
      cyc++;
      while (m_q.size() > 0 && m_q[0].due < cyc) void'(m_q.pop_front());
      g0 = req0_valid && (!req1_valid || m_ptr == 1'b0);
      g1 = req1_valid && (!req0_valid || m_ptr == 1'b1);
      if (g0 || g1) begin
        id = g1;
        we = id ? req1_we : req0_we;
        a  = id ? req1_addr : req0_addr;
        d  = id ? req1_wdata : req0_wdata;
        m_we = we; m_addr = a; m_data = d;
        if (we) shadow[a] = d;
        else m_q.push_back('{due: cyc + 1, id: id, data: shadow[a]});
        m_ptr = ~id;
      end else begin
        m_we = 1'b0;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    bit e_r0, e_r1, e_v0, e_v1;
    logic [7:0] e_d;
    e_r0 = req0_valid && (!req1_valid || m_ptr == 1'b0);
    e_r1 = req1_valid && (!req0_valid || m_ptr == 1'b1);
    e_v0 = 1'b0; e_v1 = 1'b0; e_d = 8'h00;
    if (!rst && m_q.size() > 0 && m_q[0].due == cyc) begin
      e_d = m_q[0].data;
      if (m_q[0].id) e_v1 = 1'b1; else e_v0 = 1'b1;
    end
    check("ready0", req0_ready, e_r0);
    check("ready1", req1_ready, e_r1);
    check("one_ready", req0_ready & req1_ready, 0);
    check("ram_we", ram_we, m_we);
    check("ram_addr", ram_addr, m_addr);
    check("ram_data", ram_data, m_data);
    check("rvalid0", req0_rvalid, e_v0);
    check("rdata0", req0_rdata, e_v0 ? e_d : 8'h00);
    check("rvalid1", req1_rvalid, e_v1);
    check("rdata1", req1_rdata, e_v1 ? e_d : 8'h00);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input bit v, input bit we, input int a, input int d);
    req0_valid = v; req0_we = we; req0_addr = 6'(a); req0_wdata = 8'(d);
  endtask

  task automatic set1(input bit v, input bit we, input int a, input int d);
    req1_valid = v; req1_we = we; req1_addr = 6'(a); req1_wdata = 8'(d);
  endtask

  initial begin
    logic [7:0] lone_exp [4];
    lone_exp[0] = 8'h01; lone_exp[1] = 8'h04; lone_exp[2] = 8'h05; lone_exp[3] = 8'h00;

    // reset state
    @(negedge clk);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_rvalid0", req0_rvalid, 0);
    check("rst_rdata1", req1_rdata, 0);
    next_cycle();
    rst = 1'b0;

    // single writer then readback
    for (int j = 0; j < 3; j++) begin
      set0(1, 1, j, j + 1);
      @(negedge clk);
      check("t1_wr_ready0", req0_ready, 1);
      if (j > 0) check("t1_wr_we", ram_we, 1);
      next_cycle();
    end
    for (int j = 0; j < 5; j++) begin
      if (j < 3) set0(1, 0, j, 0); else set0(0, 0, 0, 0);
      @(negedge clk);
      if (j < 3) check("t1_rd_ready0", req0_ready, 1);
      if (j == 0) check("t1_we_last", ram_we, 1);
      if (j == 1) check("t1_we_off", ram_we, 0);
      if (j >= 2) begin
        check("t1_rvalid0", req0_rvalid, 1);
        check("t1_rdata0", req0_rdata, j - 1);
      end
      next_cycle();
    end

    // contention after reset: grants alternate starting with requester 0
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin set0(1, 0, 0, 0); set1(1, 0, 1, 0); end
      else begin set0(0, 0, 0, 0); set1(0, 0, 0, 0); end
      @(negedge clk);
      if (k < 4) begin
        check("t2_ready0", req0_ready, (k % 2 == 0) ? 1 : 0);
        check("t2_ready1", req1_ready, (k % 2 == 1) ? 1 : 0);
      end
      if (k >= 2) begin
        check("t2_rvalid0", req0_rvalid, (k % 2 == 0) ? 1 : 0);
        check("t2_rvalid1", req1_rvalid, (k % 2 == 1) ? 1 : 0);
        check("t2_rdata0", req0_rdata, (k % 2 == 0) ? 8'h01 : 8'h00);
        check("t2_rdata1", req1_rdata, (k % 2 == 1) ? 8'h02 : 8'h00);
      end
      next_cycle();
    end

    // write then read of the same address on the next cycle
    for (int k = 0; k < 4; k++) begin
      if (k == 0) set1(1, 1, 1, 4); else set1(0, 0, 0, 0);
      if (k == 1) set0(1, 0, 1, 0); else set0(0, 0, 0, 0);
      @(negedge clk);
      if (k == 0) check("t3_ready1", req1_ready, 1);
      if (k == 1) check("t3_ready0", req0_ready, 1);
      if (k == 3) begin
        check("t3_rvalid0", req0_rvalid, 1);
        check("t3_rdata0", req0_rdata, 8'h04);
      end
      next_cycle();
    end

    // idle hold after a write to @2
    for (int k = 0; k < 7; k++) begin
      if (k == 0) set0(1, 1, 2, 5); else set0(0, 0, 0, 0);
      @(negedge clk);
      if (k >= 1) check("t4_addr_hold", ram_addr, 2);
      if (k >= 2) begin
        check("t4_we_off", ram_we, 0);
        check("t4_no_rvalid", req0_rvalid | req1_rvalid, 0);
      end
      next_cycle();
    end

    // reset while a read is in flight
    set0(1, 0, 3, 0);
    @(negedge clk);
    check("t5_ready0", req0_ready, 1);
    next_cycle();
    set0(0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("t5_ram_addr", ram_addr, 0);
    check("t5_ram_we", ram_we, 0);
    check("t5_ram_data", ram_data, 0);
    check("t5_rvalid", req0_rvalid | req1_rvalid, 0);
    check("t5_rdata", req0_rdata | req1_rdata, 0);
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_no_rvalid", req0_rvalid | req1_rvalid, 0);
      next_cycle();
    end
    for (int k = 0; k < 5; k++) begin
      if (k < 2) begin set0(1, 0, 0, 0); set1(1, 0, 1, 0); end
      else begin set0(0, 0, 0, 0); set1(0, 0, 0, 0); end
      @(negedge clk);
      if (k == 0) begin
        check("t5_first_ready0", req0_ready, 1);
        check("t5_first_ready1", req1_ready, 0);
      end
      if (k == 1) check("t5_second_ready1", req1_ready, 1);
      next_cycle();
    end

    // lone requester 1, back-to-back reads
    for (int k = 0; k < 6; k++) begin
      if (k < 4) set1(1, 0, k, 0); else set1(0, 0, 0, 0);
      @(negedge clk);
      if (k < 4) check("t6_ready1", req1_ready, 1);
      if (k >= 2) begin
        check("t6_rvalid1", req1_rvalid, 1);
        check("t6_rdata1", req1_rdata, lone_exp[k - 2]);
        check("t6_rvalid0", req0_rvalid, 0);
      end
      next_cycle();
    end

    repeat (3) next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_arbiter_2p.md
Name: ram_arbiter_2p

Overview:
Two-requester round-robin arbiter and sequencer for the shared single_port_ram (8-bit data, 6-bit address, write-enable, registered read).
- Accepts at most one read or write command per cycle from requester 0 or 1.
- Drives the RAM command pins from registers.
- Routes the RAM read data back to the requester that issued the read, with a valid strobe.
- Sits between two datapath clients and one RAM instance.

Parameters:
- DATA_W, 8, RAM data width.
- ADDR_W, 6, RAM address width (64 words).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 command valid
- req0_we  in  1  1 = write, 0 = read
- req0_addr  in  ADDR_W  command address
- req0_wdata  in  DATA_W  write data
- req0_ready  out  1  command accepted this cycle (grant)
- req0_rvalid  out  1  read data valid for requester 0
- req0_rdata  out  DATA_W  read data
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, req1_rvalid, req1_rdata: same as requester 0, for requester 1
- ram_data  out  DATA_W  to RAM data
- ram_addr  out  ADDR_W  to RAM addr
- ram_we  out  1  to RAM we
- ram_q  in  DATA_W  from RAM q; valid the cycle after the address is presented

Behaviour:
- Reset (async, rst=1), all forced immediately:
  - ram_we=0, ram_addr=0, ram_data=0.
  - Both rvalid=0, both rdata=0.
  - Priority pointer = requester 0.
  - Read pipeline flags cleared.
- readyN is combinational from the valids and the priority pointer:
  - Only one valid → that requester gets ready=1.
  - Both valid → the pointer's requester wins; the other gets ready=0.
  - No valid → both ready=0.
  - Never both ready=1 in the same cycle.
- Acceptance = validN & readyN in cycle N.
  - On the following rising edge, register ram_addr/ram_data/ram_we from the winner's command.
  - These drive the RAM during cycle N+1; a write commits at the end of N+1.
- No acceptance in a cycle: ram_we=0 next cycle; ram_addr and ram_data hold their last values.
- Pointer update on acceptance: pointer moves to the requester that was not granted. A lone requester may be granted every cycle (back-to-back, full throughput).
- Read return:
  - Accepted read in cycle N: tag (requester id) shifts through a 2-stage valid/id pipeline.
  - In cycle N+2, reqX_rvalid=1 for exactly one cycle with reqX_rdata=ram_q.
  - Otherwise rdata=0 (gated).
  - Writes never produce rvalid.
- Ordering: commands reach the RAM in acceptance order.
  - A write accepted in N followed by a read of the same address in N+1 returns the new data.
  - Read returns are in order; reads accepted back-to-back give rvalid on consecutive cycles.
- Interleaved reads from both requesters: each returns only on its own rvalid; the other requester's rvalid stays 0 that cycle.
- Requesters must hold valid/we/addr/wdata stable until ready; the arbiter does not check this.
- Reset mid-operation: in-flight reads are discarded (no rvalid after reset release); a pending write with ram_we high is dropped.
- Latency: accept→RAM pins 1 cycle; accept→read data 2 cycles. No combinational path from ram_q to any ready.

Test Plan:
- Single writer, then readback:
  - Stimulus: req0 writes 0x01@0, 0x02@1, 0x03@2 on consecutive cycles, then reads @0,@1,@2.
  - Required: ready0=1 every cycle; ram_we=1 for 3 cycles then 0; rvalid0 pulses 3 consecutive cycles with rdata 0x01, 0x02, 0x03, each 2 cycles after its accept.
- Contention, round-robin:
  - Stimulus: after reset, both requesters hold valid reads (req0 @0, req1 @1) continuously for 4 cycles.
  - Required: grants alternate 0,1,0,1; rvalid0 returns 0x01, rvalid1 returns 0x02; never both ready in one cycle.
- Write-then-read hazard:
  - Stimulus: req1 writes 0x04@1, and req0 reads @1 in the next cycle.
  - Required: rvalid0 data = 0x04.
- Idle hold:
  - Stimulus: no valids for 5 cycles after a write to @2.
  - Required: ram_we=0, ram_addr stays 2, no rvalid pulses.
- Reset mid-read:
  - Stimulus: req0 read @3 accepted, then rst asserted the next cycle for 1 cycle.
  - Required: all outputs 0 immediately; no rvalid after release; the next contention grants requester 0 first.
- Lone requester after contention:
  - Stimulus: req1 issues reads @0..@3 alone.
  - Required: granted all 4 back-to-back; 4 consecutive rvalid1 pulses with correct data.
